// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared opcode type and helpers for the instruction register pipe
//
// Contents:
//   opcode_t   - 3-bit ALU opcode, ZERO=0 .. MOD=7
//   is_div_op  - true for opcodes that divide by op_b (DIV, MOD)
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    function automatic logic is_div_op(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/instr_alu.sv
// rtl/instr_alu.sv - combinational signed ALU between the S1 and S2 write stages
//
// Ports:
//   opc      in   opcode_t            operation select
//   op_a     in   OP_WIDTH signed     first operand
//   op_b     in   OP_WIDTH signed     second operand
//   res      out  RES_WIDTH signed    result (0 on divide by zero)
//   div_err  out  1                   DIV/MOD with op_b == 0
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 2 * OP_WIDTH
) (
    input  opcode_t                     opc,
    input  logic signed [OP_WIDTH-1:0]  op_a,
    input  logic signed [OP_WIDTH-1:0]  op_b,
    output logic signed [RES_WIDTH-1:0] res,
    output logic                        div_err
);

    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;

    // RES_WIDTH > OP_WIDTH, so the most-negative / -1 quotient cannot overflow.
    assign a_ext = {{(RES_WIDTH - OP_WIDTH){op_a[OP_WIDTH-1]}}, op_a};
    assign b_ext = {{(RES_WIDTH - OP_WIDTH){op_b[OP_WIDTH-1]}}, op_b};

    always_comb begin
        res     = '0;
        div_err = 1'b0;
        if (is_div_op(opc) && (b_ext == '0)) begin
            div_err = 1'b1;
        end else begin
            case (opc)
                ZERO:    res = '0;
                PASSA:   res = a_ext;
                PASSB:   res = b_ext;
                ADD:     res = a_ext + b_ext;
                SUB:     res = a_ext - b_ext;
                MULT:    res = a_ext * b_ext;
                // Signed / and % truncate toward zero; remainder follows op_a.
                DIV:     res = a_ext / b_ext;
                MOD:     res = a_ext % b_ext;
                default: res = '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - pipelined instruction register file with ALU and S2 forwarding
//
// Ports:
//   clk               in   1         rising-edge clock
//   reset             in   1         synchronous active-high reset
//   load_en           in   1         write request
//   write_pointer     in   AW        write target entry
//   opcode            in   opcode_t  write operation
//   operand_a/_b      in   OP_WIDTH  signed write operands
//   read_pointer      in   AW        entry to read (one-cycle latency)
//   instruction_word  out  IW        {opc, op_a, op_b, res, valid, div_err}, registered
//   busy              out  1         a write is in S1 or S2
//   entry_count       out  AW+1      number of valid entries
//
// Write path: edge N captures into S1, edge N+1 runs the ALU into S2,
// edge N+2 commits S2 to the array. Reads hitting the S2 entry are forwarded.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter  int OP_WIDTH  = 32,
    parameter  int DEPTH     = 32,
    parameter  int RES_WIDTH = 2 * OP_WIDTH,
    localparam int AW        = $clog2(DEPTH),
    localparam int IW        = 3 + 2 * OP_WIDTH + RES_WIDTH + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [AW-1:0]              write_pointer,
    input  opcode_t                    opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic [AW-1:0]              read_pointer,
    output logic [IW-1:0]              instruction_word,
    output logic                       busy,
    output logic [AW:0]                entry_count
);

    typedef struct packed {
        opcode_t                      opc;
        logic signed [OP_WIDTH-1:0]   op_a;
        logic signed [OP_WIDTH-1:0]   op_b;
        logic signed [RES_WIDTH-1:0]  res;
        logic                         valid;
        logic                         div_err;
    } instr_t;

    // Stage S1: captured write request.
    logic                       s1_valid;
    logic [AW-1:0]              s1_addr;
    opcode_t                    s1_opc;
    logic signed [OP_WIDTH-1:0] s1_a;
    logic signed [OP_WIDTH-1:0] s1_b;

    // Stage S2: fully formed entry awaiting commit.
    logic                       s2_valid;
    logic [AW-1:0]              s2_addr;
    instr_t                     s2_word;

    logic signed [RES_WIDTH-1:0] alu_res;
    logic                        alu_div_err;

    // Data storage is never reset; entry_valid gates every read.
    instr_t                     mem [DEPTH];
    logic [DEPTH-1:0]           entry_valid;
    instr_t                     rd_word;

    instr_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH)
    ) u_alu (
        .opc     (s1_opc),
        .op_a    (s1_a),
        .op_b    (s1_b),
        .res     (alu_res),
        .div_err (alu_div_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= load_en;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            s1_addr <= write_pointer;
            s1_opc  <= opcode;
            s1_a    <= operand_a;
            s1_b    <= operand_b;
        end
        if (s1_valid) begin
            s2_addr <= s1_addr;
            s2_word <= '{opc: s1_opc, op_a: s1_a, op_b: s1_b, res: alu_res,
                         valid: 1'b1, div_err: alu_div_err};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && s2_valid) begin
            mem[s2_addr] <= s2_word;
        end
    end

    // Commits are strictly in order, so back-to-back writes to one entry
    // count once and the younger one lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid <= '0;
            entry_count <= '0;
        end else if (s2_valid) begin
            entry_valid[s2_addr] <= 1'b1;
            if (!entry_valid[s2_addr]) begin
                entry_count <= entry_count + (AW + 1)'(1);
            end
        end
    end

    // S2 is committed on this same edge, so the array still holds the old
    // value; forward S2 to make the write visible to this read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word <= '0;
        end else if (s2_valid && (s2_addr == read_pointer)) begin
            rd_word <= s2_word;
        end else if (entry_valid[read_pointer]) begin
            rd_word <= mem[read_pointer];
        end else begin
            rd_word <= '0;
        end
    end

    assign instruction_word = rd_word;
    assign busy             = s1_valid | s2_valid;

endmodule

// File: tb/tb_instr_register_pipe.sv
// tb/tb_instr_register_pipe.sv - scoreboard testbench for instr_register_pipe
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    localparam int OPW = 32;
    localparam int RSW = 64;
    localparam int DEP = 32;
    localparam int AWT = 5;
    localparam int IWT = 3 + 2 * OPW + RSW + 2;

    typedef struct packed {
        opcode_t                 opc;
        logic signed [OPW-1:0]   op_a;
        logic signed [OPW-1:0]   op_b;
        logic signed [RSW-1:0]   res;
        logic                    valid;
        logic                    div_err;
    } word_t;

    typedef struct {
        int    cyc;
        bit    is_cnt;
        word_t word;
        int    cnt;
        bit    bsy;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  load_en;
    logic [AWT-1:0]        write_pointer;
    opcode_t               opcode;
    logic signed [OPW-1:0] operand_a;
    logic signed [OPW-1:0] operand_b;
    logic [AWT-1:0]        read_pointer;
    logic [IWT-1:0]        instruction_word;
    logic                  busy;
    logic [AWT:0]          entry_count;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e;
    string nm;
    word_t act;

    instr_register_pipe #(
        .OP_WIDTH  (OPW),
        .DEPTH     (DEP),
        .RES_WIDTH (RSW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .entry_count      (entry_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic word_t mk(input opcode_t opc, input int a, input int b,
                                 input longint r, input bit de);
        word_t w;
        w.opc = opc; w.op_a = a; w.op_b = b; w.res = r;
        w.valid = 1'b1; w.div_err = de;
        return w;
    endfunction

    task automatic drive(input bit we, input int wp, input opcode_t opc,
                         input int a, input int b, input int rp);
        load_en       = we;
        write_pointer = wp[AWT-1:0];
        opcode        = opc;
        operand_a     = a;
        operand_b     = b;
        read_pointer  = rp[AWT-1:0];
    endtask

    // Expectations refer to the upcoming edge, which samples the current inputs.
    task automatic exp_rd(input string n, input word_t w);
        exp_t x;
        x.cyc = cyc + 1; x.is_cnt = 1'b0; x.word = w; x.cnt = 0; x.bsy = 1'b0;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    task automatic exp_cnt(input string n, input int c, input bit b);
        exp_t x;
        x.cyc = cyc + 1; x.is_cnt = 1'b1; x.word = '0; x.cnt = c; x.bsy = b;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 0, ZERO, 0, 0, 0);
        exp_rd("reset_word", '0);
        exp_cnt("reset_cnt", 0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            act = instruction_word;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", nm, e.cyc, cyc);
            end else if (e.is_cnt) begin
                if (entry_count !== (AWT + 1)'(e.cnt) || busy !== e.bsy) begin
                    failures++;
                    $display("FAIL %s @%0d: entry_count=%0d busy=%b, expected entry_count=%0d busy=%b",
                             nm, cyc, entry_count, busy, e.cnt, e.bsy);
                end
            end else if (instruction_word !== e.word) begin
                failures++;
                $display("FAIL %s @%0d: got opc=%0d a=%0d b=%0d res=%0d valid=%b div_err=%b, expected opc=%0d a=%0d b=%0d res=%0d valid=%b div_err=%b",
                         nm, cyc, act.opc, act.op_a, act.op_b, act.res, act.valid, act.div_err,
                         e.word.opc, e.word.op_a, e.word.op_b, e.word.res, e.word.valid, e.word.div_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, ZERO, 0, 0, 0);
        tick();

        // Empty array after reset.
        do_reset();
        for (int i = 0; i < DEP; i++) begin
            drive(1'b0, 0, ZERO, 0, 0, i);
            exp_rd("empty_read", '0);
            exp_cnt("empty_cnt", 0, 1'b0);
            tick();
        end

        // ADD 7 + -3 to address 5, read address 5 every cycle.
        do_reset();
        drive(1'b1, 5, ADD, 7, -3, 5);
        exp_rd("add_edge_n", '0);          exp_cnt("add_cnt_n", 0, 1'b1);   tick();
        drive(1'b0, 0, ZERO, 0, 0, 5);
        exp_rd("add_n1_stale", '0);        exp_cnt("add_cnt_n1", 0, 1'b1);  tick();
        exp_rd("add_n2_fwd", mk(ADD, 7, -3, 4, 1'b0));
        exp_cnt("add_cnt_n2", 1, 1'b0);    tick();
        exp_rd("add_n3_array", mk(ADD, 7, -3, 4, 1'b0));
        exp_cnt("add_cnt_n3", 1, 1'b0);    tick();

        // Division, multiply, SUB and ZERO, issued back to back.
        do_reset();
        drive(1'b1, 8, DIV, -7, 2, 8);      exp_rd("div_pre", '0);   tick();
        drive(1'b1, 9, MOD, -7, 2, 9);      exp_rd("mod_pre", '0);   tick();
        drive(1'b1, 10, DIV, 9, 0, 8);
        exp_rd("div_fwd", mk(DIV, -7, 2, -3, 1'b0));                 tick();
        drive(1'b1, 11, MULT, 32'sh8000_0000, 32'sh8000_0000, 9);
        exp_rd("mod_fwd", mk(MOD, -7, 2, -1, 1'b0));                 tick();
        drive(1'b1, 12, SUB, 5, 9, 10);
        exp_rd("div0_fwd", mk(DIV, 9, 0, 0, 1'b1));
        exp_cnt("div_cnt4", 3, 1'b1);                                tick();
        drive(1'b1, 13, ZERO, 3, 4, 11);
        exp_rd("mult_fwd", mk(MULT, 32'sh8000_0000, 32'sh8000_0000, 64'sh4000_0000_0000_0000, 1'b0));
        exp_cnt("div_cnt5", 4, 1'b1);                                tick();
        drive(1'b0, 0, ZERO, 0, 0, 12);
        exp_rd("sub_fwd", mk(SUB, 5, 9, -4, 1'b0));                  tick();
        drive(1'b0, 0, ZERO, 0, 0, 13);
        exp_rd("zero_fwd", mk(ZERO, 3, 4, 0, 1'b0));
        exp_cnt("div_cnt7", 6, 1'b0);                                tick();
        drive(1'b0, 0, ZERO, 0, 0, 8);
        exp_rd("div_array", mk(DIV, -7, 2, -3, 1'b0));               tick();
        drive(1'b0, 0, ZERO, 0, 0, 10);
        exp_rd("div0_array", mk(DIV, 9, 0, 0, 1'b1));                tick();

        // Back-to-back writes to address 3: younger wins.
        do_reset();
        drive(1'b1, 3, PASSA, 10, 0, 3);    exp_rd("b2b_pre0", '0);  tick();
        drive(1'b1, 3, PASSB, 0, 20, 3);    exp_rd("b2b_pre1", '0);  tick();
        drive(1'b0, 0, ZERO, 0, 0, 3);
        exp_rd("b2b_first", mk(PASSA, 10, 0, 10, 1'b0));
        exp_cnt("b2b_cnt2", 1, 1'b1);                                tick();
        exp_rd("b2b_second", mk(PASSB, 0, 20, 20, 1'b0));
        exp_cnt("b2b_cnt3", 1, 1'b0);                                tick();
        exp_rd("b2b_array", mk(PASSB, 0, 20, 20, 1'b0));
        exp_cnt("b2b_cnt4", 1, 1'b0);                                tick();

        // Reset while a write is in flight; load_en ignored during reset.
        do_reset();
        drive(1'b1, 2, PASSA, 1, 0, 2);
        exp_rd("flush_pre", '0);           exp_cnt("flush_cnt0", 0, 1'b1);  tick();
        reset = 1'b1;
        drive(1'b1, 4, PASSA, 2, 0, 2);
        exp_rd("flush_rst_word", '0);      exp_cnt("flush_cnt1", 0, 1'b0);  tick();
        reset = 1'b0;
        drive(1'b0, 0, ZERO, 0, 0, 2);
        exp_rd("flush_rd2_a", '0);         exp_cnt("flush_cnt2", 0, 1'b0);  tick();
        drive(1'b0, 0, ZERO, 0, 0, 4);
        exp_rd("flush_rd4", '0);           exp_cnt("flush_cnt3", 0, 1'b0);  tick();
        drive(1'b0, 0, ZERO, 0, 0, 2);
        exp_rd("flush_rd2_b", '0);         exp_cnt("flush_cnt4", 0, 1'b0);  tick();

        // Fill all 32 entries, then wrap address 32 onto entry 0.
        do_reset();
        for (int k = 0; k < DEP; k++) begin
            drive(1'b1, k, PASSA, k + 100, k, (k >= 2) ? k - 2 : 31);
            if (k >= 2) exp_rd("fill_fwd", mk(PASSA, k + 98, k - 2, k + 98, 1'b0));
            else        exp_rd("fill_pre", '0);
            exp_cnt("fill_cnt", (k == 0) ? 0 : k - 1, 1'b1);
            tick();
        end
        drive(1'b1, 32, PASSB, 7, 555, 30);
        exp_rd("wrap_fwd30", mk(PASSA, 130, 30, 130, 1'b0));
        exp_cnt("wrap_cnt31", 31, 1'b1);                             tick();
        drive(1'b0, 0, ZERO, 0, 0, 31);
        exp_rd("wrap_fwd31", mk(PASSA, 131, 31, 131, 1'b0));
        exp_cnt("wrap_cnt32", 32, 1'b1);                             tick();
        drive(1'b0, 0, ZERO, 0, 0, 0);
        exp_rd("wrap_fwd0", mk(PASSB, 7, 555, 555, 1'b0));
        exp_cnt("wrap_cnt_after", 32, 1'b0);                         tick();
        exp_rd("wrap_array0", mk(PASSB, 7, 555, 555, 1'b0));
        exp_cnt("wrap_cnt_final", 32, 1'b0);                         tick();
        drive(1'b0, 0, ZERO, 0, 0, 1);
        exp_rd("wrap_array1", mk(PASSA, 101, 1, 101, 1'b0));         tick();

        tick();
        tick();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_register_pipe.md
INSTR_REGISTER_PIPE -- requirements
Module: instr_register_pipe

Interface
REQ-001 Parameter OP_WIDTH, default 32: signed operand width in bits, minimum 4.
REQ-002 Parameter DEPTH, default 32: number of register entries, power of two from 4 to 256; AW = $clog2(DEPTH).
REQ-003 Parameter RES_WIDTH, default 2*OP_WIDTH: signed result width, minimum OP_WIDTH+1.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  write request, sampled each edge.
REQ-007 write_pointer  input  AW  target entry of the write.
REQ-008 opcode  input  3  opcode_t.
REQ-009 operand_a, operand_b  input  OP_WIDTH each  signed operands.
REQ-010 read_pointer  input  AW  entry to read, sampled each edge.
REQ-011 instruction_word  output  struct  fields {opc, op_a, op_b, res[RES_WIDTH], valid, div_err}, registered.
REQ-012 busy  output  1  high while any write is still in the pipeline.
REQ-013 entry_count  output  AW+1  number of valid entries.

Function
REQ-014 The write path SHALL have three edges:
- Edge N: load_en=1 captures the write into stage S1.
- Edge N+1: the S1 result is computed and captured into S2.
- Edge N+2: S2 is committed to the array.
REQ-015 The write path SHALL accept one write per cycle, with no stall and no back-pressure.
REQ-016 Reads SHALL have one-cycle latency: read_pointer sampled at edge E appears on instruction_word after edge E.
REQ-017 Forwarding: when a read sampled at edge E targets the entry held in S2, instruction_word SHALL return the S2 contents.
- Consequence: a write sampled at edge N is visible to reads sampled at edge N+2 or later.
- Reads sampled at edge N or N+1 return the prior contents.
REQ-018 Reading an entry that has never been written SHALL return all fields 0, including valid=0.
REQ-019 Arithmetic SHALL sign-extend both operands to RES_WIDTH, then compute:
- ZERO: 0.
- PASSA: op_a.
- PASSB: op_b.
- ADD: op_a+op_b.
- SUB: op_a-op_b.
- MULT: full product, truncated to RES_WIDTH.
- DIV: quotient truncated toward zero.
- MOD: remainder carrying the sign of op_a.
REQ-020 For DIV or MOD with op_b=0, the block SHALL store res=0 and div_err=1; div_err SHALL be 0 in every other case.
REQ-021 A write to an invalid entry SHALL increment entry_count at commit; overwriting a valid entry SHALL leave entry_count unchanged.
REQ-022 For back-to-back writes to the same address, the younger write SHALL win both at commit and in forwarding.
REQ-023 busy SHALL equal (S1 valid OR S2 valid).
REQ-024 write_pointer and read_pointer SHALL address modulo DEPTH, with no out-of-range condition.

Reset
REQ-025 Reset SHALL clear the following:
- S1 and S2 valid bits.
- All entry valid bits.
- entry_count to 0.
- instruction_word to all-zero.
- busy to 0.
REQ-026 Reset asserted while writes are in flight SHALL discard them uncommitted; load_en SHALL be ignored while reset=1.
REQ-027 Array data storage need not be cleared, because the valid bits gate every read.

Structure
REQ-028 opcode_t (ZERO=0 … MOD=7) SHALL be defined in instr_register_pkg; the parametrised instruction struct SHALL be declared locally from the module parameters.
REQ-029 The arithmetic SHALL be implemented in one combinational sub-module, instr_alu, parametrised by OP_WIDTH and RES_WIDTH and placed between S1 and S2.

Verification (OP_WIDTH=32, DEPTH=32)
REQ-030 Reset, then read addresses 0..31 -> every read returns valid=0 and res=0; entry_count=0; busy=0.
REQ-031 ADD a=7 b=-3 to address 5 at edge N, reading address 5 every cycle:
- Read sampled at N+1 -> valid=0.
- Read sampled at N+2 -> res=4, valid=1.
- entry_count=1.
REQ-032 Division cases:
- DIV a=-7 b=2 -> res=-3.
- MOD a=-7 b=2 -> res=-1.
- DIV a=9 b=0 -> res=0, div_err=1.
- MULT a=-2^31 b=-2^31 -> res=2^62.
REQ-033 Back-to-back writes to address 3 (PASSA a=10, then PASSB b=20) -> consecutive reads show 10 then 20; entry_count=1.
REQ-034 Write at edge N, reset=1 at edge N+1 -> no commit; busy=0 and entry_count=0 after reset.
REQ-035 Write addresses 0..31, then write address 32 (wraps to 0) -> entry_count=32 after the first 32 writes and still 32 after the wrap; address 0 returns the new data.
